// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: word width, demux select codes, stage states.
// Used by demux1_to_2_stream (DEMUX_STATS_EN adds per-channel counters).
package alu_pkg;
  localparam int ALU_DATA_W = 8;
  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_st_e;
endpackage

// File: rtl/out_stage_reg.sv
// One-entry valid/ready output register: load, drain, flush.
// DEMUX_STATS_EN adds a wrapping 16-bit output-transfer counter.
module out_stage_reg
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]       cnt
`endif
);

  stage_st_e         st_q, st_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              xfer;

  assign xfer = (st_q == ST_FULL) && out_ready;

  // flush wins over any load or drain in the same cycle
  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    if (flush) begin
      st_d   = ST_EMPTY;
      data_d = '0;
    end else if (load) begin
      st_d   = ST_FULL;
      data_d = load_data;
    end else if (xfer) begin
      st_d   = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_EMPTY;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
    end
  end

  assign out_valid = (st_q == ST_FULL);
  assign out_data  = data_q;

`ifdef DEMUX_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else if (xfer) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux1_to_2_stream.sv
// Registered 1-to-2 stream demux from ALU result bus to two consumers.
// DEMUX_STATS_EN adds cnt0/cnt1 output-transfer counters.
module demux1_to_2_stream
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
`endif
);

  logic room0, room1, in_xfer;
  logic load0, load1;

  assign room0 = !out0_valid || out0_ready;
  assign room1 = !out1_valid || out1_ready;

  // only the selected stage gates the input
  assign in_ready = !flush &&
                    ((in_sel == SEL_OUT1) ? room1 : room0);
  assign in_xfer  = in_valid && in_ready;
  assign load0    = in_xfer && (in_sel == SEL_OUT0);
  assign load1    = in_xfer && (in_sel == SEL_OUT1);

  out_stage_reg #(.DATA_W(DATA_W)) u_out0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load0),
    .load_data (in_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data)
`ifdef DEMUX_STATS_EN
    ,
    .cnt       (cnt0)
`endif
  );

  out_stage_reg #(.DATA_W(DATA_W)) u_out1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .load      (load1),
    .load_data (in_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .cnt       (cnt1)
`endif
  );

endmodule

// File: tb/tb_demux1_to_2_stream.sv
// Bench for demux1_to_2_stream: vector table plus per-channel scoreboard.
// Counter checks are compiled in when DEMUX_STATS_EN is defined.
module tb_demux1_to_2_stream;

  logic       clk = 1'b0;
  logic       rst_n, flush;
  logic       in_valid, in_ready, in_sel;
  logic [7:0] in_data;
  logic       out0_valid, out0_ready;
  logic [7:0] out0_data;
  logic       out1_valid, out1_ready;
  logic [7:0] out1_data;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0, cnt1;
  logic [15:0] mc0, mc1;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       z0, z1;

  always #5 clk = ~clk;

  demux1_to_2_stream #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t",
               n, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic s,
                        input logic [7:0] d, input logic r0,
                        input logic r1, input logic fl);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    flush      = fl;
  endtask

  // scoreboard: sampled at negedge, transfers happen at the next posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      z0 = 1'b1;
      z1 = 1'b1;
`ifdef DEMUX_STATS_EN
      mc0 = '0;
      mc1 = '0;
`endif
    end else begin
      logic er;
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
      else if (z0) chk("out0_data_zero", 32'(out0_data), 0);
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
      else if (z1) chk("out1_data_zero", 32'(out1_data), 0);
      er = !flush && (in_sel ? (q1.size() == 0 || out1_ready)
                             : (q0.size() == 0 || out0_ready));
      chk("in_ready_model", 32'(in_ready), 32'(er));
`ifdef DEMUX_STATS_EN
      chk("cnt0", 32'(cnt0), 32'(mc0));
      chk("cnt1", 32'(cnt1), 32'(mc1));
`endif
      if (flush) begin
        q0.delete();
        q1.delete();
        z0 = 1'b1;
        z1 = 1'b1;
`ifdef DEMUX_STATS_EN
        mc0 = '0;
        mc1 = '0;
`endif
      end else begin
        if (q0.size() != 0 && out0_ready) begin
          void'(q0.pop_front());
          pops++;
`ifdef DEMUX_STATS_EN
          mc0 = mc0 + 16'd1;
`endif
        end
        if (q1.size() != 0 && out1_ready) begin
          void'(q1.pop_front());
          pops++;
`ifdef DEMUX_STATS_EN
          mc1 = mc1 + 16'd1;
`endif
        end
        if (in_valid && er) begin
          if (in_sel) begin
            q1.push_back(in_data);
            z1 = 1'b0;
          end else begin
            q0.push_back(in_data);
            z0 = 1'b0;
          end
        end
      end
    end
  end

  typedef struct {
    logic       v;
    logic       sel;
    logic [7:0] d;
    logic       r0;
    logic       r1;
    logic       fl;
    logic       rdy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int p;
    tbl[0]  = '{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_out0_valid", 32'(out0_valid), 0);
    chk("rst_out1_valid", 32'(out1_valid), 0);
    chk("rst_out0_data", 32'(out0_data), 0);
    chk("rst_out1_data", 32'(out1_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].v, tbl[i].sel, tbl[i].d,
             tbl[i].r0, tbl[i].r1, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("tbl_in_ready[%0d]", i), 32'(in_ready),
          32'(tbl[i].rdy));
      @(posedge clk);
      #1;
    end

    // full-rate alternating stream, no bubbles allowed
    p = pops;
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, i[0], 8'(i), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("stream_ready[%0d]", i), 32'(in_ready), 1);
      @(posedge clk);
      #1;
    end
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("stream_pops", 32'(pops - p), 16);

    // asynchronous reset while out0 holds a word
    set_in(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_out0_data", 32'(out0_data), 32'h A5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out0_valid", 32'(out0_valid), 0);
    chk("midrst_out0_data", 32'(out0_data), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out0_data", 32'(out0_data), 0);
    chk("post_rst_out1_valid", 32'(out1_valid), 0);

`ifdef DEMUX_STATS_EN
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("flush_cnt0", 32'(cnt0), 0);
    chk("flush_cnt1", 32'(cnt1), 0);
    for (int i = 0; i < 65537; i++) begin
      set_in(1'b1, 1'b0, 8'(i), 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
    end
    set_in(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("wrap_cnt0", 32'(cnt0), 1);
    chk("wrap_cnt1", 32'(cnt1), 0);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
